// File: rtl/d_write_buffer_if.sv
// d_write_buffer_if: sram-like request/response bus used on both sides of the write buffer.
interface d_write_buffer_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;
    modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
    modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/d_write_buffer.sv
// d_write_buffer: posted store queue between the dcache and the AXI bridge; reads bypass only an empty queue.
module d_write_buffer #(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input logic             clk,
    input logic             rst,
    d_write_buffer_if.slave  cache,
    d_write_buffer_if.master mem
);
    typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RRESP} state_t;
    state_t state;
    logic [1:0]  size_q [DEPTH];
    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [PTR_WIDTH-1:0] head, tail;
    logic [PTR_WIDTH:0]   count;
    logic        wack;
    logic [31:0] rd_addr, rdata_q;
    logic [1:0]  rd_size;
    logic full, empty, pending, push, pop, rd_acc, rd_done;
    assign full    = count == (PTR_WIDTH+1)'(DEPTH);
    assign empty   = count == '0;
    assign pending = wack | (state == RREQ) | (state == RRESP);
    // Gated by rst so nothing is acknowledged while the block is held in reset
    assign push    = rst & cache.req & cache.wr & ~full & ~pending;
    assign rd_acc  = rst & cache.req & ~cache.wr & empty & (state == IDLE) & ~pending;
    assign pop     = (state == WRESP) & mem.data_ok;
    assign rd_done = (state == RRESP) & mem.data_ok;
    assign cache.addr_ok = push | rd_acc;
    assign cache.data_ok = wack | rd_done;
    assign cache.rdata   = rd_done ? mem.rdata : rdata_q;
    assign mem.req   = (state == WREQ) | (state == RREQ);
    assign mem.wr    = state == WREQ;
    assign mem.size  = state == WREQ ? size_q[head] : state == RREQ ? rd_size : 2'b00;
    assign mem.addr  = state == WREQ ? addr_q[head] : state == RREQ ? rd_addr : 32'h0;
    assign mem.wdata = state == WREQ ? data_q[head] : 32'h0;
    always_ff @(posedge clk) begin
        if (push) begin
            size_q[tail] <= cache.size;
            addr_q[tail] <= cache.addr;
            data_q[tail] <= cache.wdata;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            wack    <= 1'b0;
            rd_addr <= 32'h0;
            rd_size <= 2'b00;
            rdata_q <= 32'h0;
        end else begin
            wack  <= push;
            head  <= pop ? head + 1'b1 : head;
            tail  <= push ? tail + 1'b1 : tail;
            count <= count + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
            if (rd_acc) begin
                rd_addr <= cache.addr;
                rd_size <= cache.size;
            end
            if (rd_done) rdata_q <= mem.rdata;
            // Pending stores always drain before a read is considered
            unique case (state)
                IDLE:    state <= !empty ? WREQ : rd_acc ? RREQ : IDLE;
                WREQ:    state <= mem.addr_ok ? WRESP : WREQ;
                WRESP:   state <= mem.data_ok ? IDLE : WRESP;
                RREQ:    state <= mem.addr_ok ? RRESP : RREQ;
                RRESP:   state <= mem.data_ok ? IDLE : RRESP;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/d_write_buffer.md
# d_write_buffer

Posted write buffer between the data cache's memory-side sram-like master port and the AXI interface's sram-like data slave port. Stores are acknowledged to the cache as soon as they are queued, then drained to memory in order in the background. Reads are forwarded only once the queue is empty, so a read always observes every earlier store. The block carries one request at a time on each side.

## Interface
- DEPTH, 4, number of write entries; must be a power of two, minimum 2
- PTR_WIDTH, 2, log2(DEPTH)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- cache_data_req  in  1  request from the data cache
- cache_data_wr  in  1  1 = write, 0 = read
- cache_data_size  in  2  byte count: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes
- cache_data_addr  in  32  byte address
- cache_data_wdata  in  32  store data
- cache_data_rdata  out  32  read data, valid while cache_data_data_ok = 1
- cache_data_addr_ok  out  1  request accepted this cycle
- cache_data_data_ok  out  1  response for the accepted request
- mem_data_req  out  1  request toward the AXI interface
- mem_data_wr  out  1  write flag of the issued request
- mem_data_size  out  2  size of the issued request
- mem_data_addr  out  32  address of the issued request
- mem_data_wdata  out  32  store data of the issued request
- mem_data_rdata  in  32  read data from memory
- mem_data_addr_ok  in  1  memory accepted the request
- mem_data_data_ok  in  1  memory response

## Operation
- FIFO: DEPTH entries of {size, addr, wdata}.
  - Head and tail pointers are PTR_WIDTH bits and wrap modulo DEPTH.
  - Occupancy count is PTR_WIDTH+1 bits.
  - full = (count == DEPTH); empty = (count == 0).
- Upstream acceptance rule: a request can be accepted only when no upstream response is pending. Pending means the write-ack register is set, or the state is RREQ or RRESP.
- Write accept:
  - Condition: cache_data_req & cache_data_wr & ~full & no pending response.
  - cache_data_addr_ok is driven high combinationally in that cycle.
  - The entry is pushed at the tail on the same edge.
  - The write-ack register is set; it produces cache_data_data_ok = 1 for exactly the next cycle.
- Read accept:
  - Condition: cache_data_req & ~cache_data_wr & empty & state == IDLE & no pending response.
  - cache_data_addr_ok = 1 combinationally.
  - addr and size are latched; state moves to RREQ.
- FSM states: IDLE, WREQ, WRESP, RREQ, RRESP.
  - IDLE → WREQ when ~empty. Draining writes takes priority over accepting reads.
  - IDLE → RREQ on read accept.
  - WREQ: mem_data_req = 1, mem_data_wr = 1, fields taken from the head entry. → WRESP on mem_data_addr_ok.
  - WRESP: mem_data_req = 0. On mem_data_data_ok, pop the head and go → IDLE.
  - RREQ: mem_data_req = 1, mem_data_wr = 0, latched addr and size. → RRESP on mem_data_addr_ok.
  - RRESP: on mem_data_data_ok, set cache_data_data_ok = 1 and cache_data_rdata = mem_data_rdata combinationally in the same cycle, then go → IDLE.
- mem_data_* fields stay stable from the cycle req rises until mem_data_addr_ok is seen.
- Simultaneous push (write accept) and pop (WRESP data_ok) in one cycle: count is unchanged and both pointers advance.
- Full: write requests get cache_data_addr_ok = 0 and the requester holds its request. It is accepted in the cycle after the next pop.
- A read arriving while the queue is non-empty is held off until the queue is empty and the state is IDLE.

## Timing
- Reset (rst = 0, asynchronous) clears:
  - state = IDLE; pointers and count = 0; write-ack register = 0.
  - All outputs = 0: cache_data_addr_ok, cache_data_data_ok, cache_data_rdata, and all mem_data_* outputs.
- Reset during a drain or read discards the queue contents and any in-flight transaction. No response is issued after reset is released.
- Write latency to the cache: addr_ok in cycle T, data_ok in T+1.
- Drain latency for an empty queue with a zero-wait memory:
  - push at edge T; WREQ from T+1; addr_ok in T+1; data_ok at the earliest in T+2.
  - Minimum of 2 cycles per entry, plus 1 IDLE cycle between entries.
- Read latency: addr_ok in cycle T, mem request from T+1, cache data_ok in the same cycle as mem_data_data_ok.
- cache_data_rdata holds its last value outside cache_data_data_ok cycles and is 0 after reset.

## Test plan
- Single write of 0xDEADBEEF to 0x00000010, size 10:
  - cache addr_ok at T, data_ok at T+1.
  - Memory then sees req/wr = 1, addr 0x10, data 0xDEADBEEF, size 10.
- Four back-to-back writes to 0x0, 0x4, 0x8, 0xC with memory addr_ok stalled:
  - All four are accepted.
  - A fifth write gets addr_ok = 0 until the first pop, then is accepted.
  - Drain order is 0x0, 0x4, 0x8, 0xC, then the fifth.
- Write 0x11223344 to 0x20, then immediately read 0x20:
  - The read's addr_ok is withheld until the write's memory data_ok.
  - The memory read is issued after the write; the cache receives memory's rdata with data_ok.
- Push and pop in the same cycle at count = 2:
  - Count stays 2; both pointers advance.
  - Wrap-around from entry 3 to entry 0 drains in correct order.
- Assert rst = 0 mid-WRESP with 3 entries queued:
  - All outputs read 0 during reset.
  - After release, no mem_data_req is issued until a new write arrives.
- Byte write: size 00, addr 0x33, wdata 0x000000AB:
  - The memory request carries size 00, addr 0x33, and wdata unchanged.
